// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Iterative 32x32 multiply / divide unit with HI/LO result registers.
//   op 0 MULT  (signed)    {hi,lo} = x * y
//   op 1 MULTU (unsigned)  {hi,lo} = x * y
//   op 2 DIV   (signed)    lo = x / y (toward zero), hi = x % y (sign of x)
//   op 3 DIVU  (unsigned)  lo = x / y, hi = x % y
// Every operation takes a fixed 34 edges: the accepting edge, 32 iteration
// edges, and one sign-fix edge. The iteration edges process one operand bit
// each and work on operand magnitudes. done pulses for the cycle after the
// fix edge. A divide by zero returns lo = all ones and hi = x, and sets
// div_by_zero until the next accepted start.
// -----------------------------------------------------------------------------
module mul_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    // op encoding: bit 1 selects divide, bit 0 selects unsigned
    localparam logic [4:0] LAST_ITER = 5'd31;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [1:0]  op_q;
    logic [31:0] x_q;
    logic [31:0] y_q;
    // Multiplicand magnitude for multiply, divisor magnitude for divide
    logic [31:0] opnd_q;
    // Multiply: {partial product high, multiplier/product low}
    // Divide:   {partial remainder, dividend/quotient}
    logic [63:0] acc_q;
    logic [63:0] acc_d;

    logic        busy_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        dbz_q;

    // Iteration step intermediates
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;

    // Sign-fix intermediates
    logic        is_signed_q;
    logic        is_div_q;
    logic        y_zero_q;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // Two's-complement magnitude of v when it is treated as signed
    function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

    // Start-edge operand magnitudes, chosen by the requested operation
    logic        req_signed;
    logic [31:0] req_opnd;
    logic [31:0] req_acc_lo;

    assign req_signed = ~op[0];
    assign req_opnd   = op[1] ? mag(y, req_signed) : mag(x, req_signed);
    assign req_acc_lo = op[1] ? mag(x, req_signed) : mag(y, req_signed);

    assign is_signed_q = ~op_q[0];
    assign is_div_q    = op_q[1];
    assign y_zero_q    = (y_q == 32'd0);

    // One shift-add or restoring shift-subtract step on the accumulator
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves
        // a value unassigned and no latch is inferred.
        acc_d     = acc_q;
        mul_sum   = 33'd0;
        div_shift = 33'd0;
        div_ge    = 1'b0;
        if (is_div_q) begin
            // Bring the next dividend bit into the partial remainder
            div_shift = {acc_q[63:32], acc_q[31]};
            div_ge    = (div_shift >= {1'b0, opnd_q});
            if (div_ge) begin
                acc_d = {div_shift[31:0] - opnd_q, acc_q[30:0], 1'b1};
            end else begin
                acc_d = {div_shift[31:0], acc_q[30:0], 1'b0};
            end
        end else begin
            // Add the multiplicand when the current multiplier bit is set
            mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
            acc_d   = {mul_sum, acc_q[31:1]};
        end
    end

    // Apply result signs and the divide-by-zero override
    always_comb begin
        prod_fix = acc_q;
        quo_fix  = acc_q[31:0];
        rem_fix  = acc_q[63:32];
        res_hi   = acc_q[63:32];
        res_lo   = acc_q[31:0];
        if (is_div_q) begin
            if (is_signed_q && (x_q[31] ^ y_q[31])) begin
                quo_fix = ~acc_q[31:0] + 32'd1;
            end
            if (is_signed_q && x_q[31]) begin
                rem_fix = ~acc_q[63:32] + 32'd1;
            end
            if (y_zero_q) begin
                res_hi = x_q;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = rem_fix;
                res_lo = quo_fix;
            end
        end else begin
            if (is_signed_q && (x_q[31] ^ y_q[31])) begin
                prod_fix = ~acc_q + 64'd1;
            end
            res_hi = prod_fix[63:32];
            res_lo = prod_fix[31:0];
        end
    end

    // Control FSM with registered outputs, operand capture and HI/LO writes
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the iteration registers are reset along with the control state,
        // so an aborted operation leaves no stale partial result behind.
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 2'd0;
            x_q     <= 32'd0;
            y_q     <= 32'd0;
            opnd_q  <= 32'd0;
            acc_q   <= 64'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            dbz_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading its
            // pre-edge value, independent of statement order in this block.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // A start on this edge takes priority over direct writes
                        op_q    <= op;
                        x_q     <= x;
                        y_q     <= y;
                        opnd_q  <= req_opnd;
                        acc_q   <= {32'd0, req_acc_lo};
                        cnt_q   <= 5'd0;
                        dbz_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        if (hi_we) begin
                            hi_q <= wdata;
                        end
                        if (lo_we) begin
                            lo_q <= wdata;
                        end
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LAST_ITER) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    hi_q    <= res_hi;
                    lo_q    <= res_lo;
                    dbz_q   <= is_div_q && y_zero_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
// Directed vectors for mul_div_unit. The driver pushes the hand-computed
// result of every accepted operation into a scoreboard queue; a monitor pops
// and compares whenever done is high, including the 34-edge latency.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_vec;
    int   n_miss;

    mul_div_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .x           (x),
        .y           (y),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge counter used to measure latency
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_done: got done=1, expected no pending operation (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                check("result_hi", {32'd0, hi}, {32'd0, e.hi});
                check("result_lo", {32'd0, lo}, {32'd0, e.lo});
                check("result_dbz", {63'd0, div_by_zero}, {63'd0, e.dbz});
                // Done is seen after the 33rd edge following the accepting edge
                check("latency", 64'(cyc - e.acc), 64'd33);
                check("busy_at_done", {63'd0, busy}, 64'd0);
            end
        end
    end

    // Present a start for one edge (caller ensures the unit is idle) and record
    // the expected result together with the accepting edge
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic ed);
        exp_t e;
        start = 1'b1;
        op    = o;
        x     = a;
        y     = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        e.hi   = eh;
        e.lo   = el;
        e.dbz  = ed;
        e.acc  = cyc;
        sb.push_back(e);
        check("busy_after_accept", {63'd0, busy}, 64'd1);
    endtask

    // Wait (bounded) for the done cycle; returns at that cycle's falling edge
    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) break;
        end
        if (!done) begin
            n_vec++;
            n_miss++;
            $display("FAIL done_timeout: got done=0, expected done within 40 cycles (t=%0t)", $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 2'd0;
        x      = 32'd0;
        y      = 32'd0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        wdata  = 32'd0;
        #12;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        check("reset_dbz", {63'd0, div_by_zero}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // MULT -2 * 3 = -6
        issue(2'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        wait_done();
        // MULTU started back-to-back on the done cycle
        issue(2'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);
        check("hold_hi_in_run", {32'd0, hi}, {32'd0, 32'hFFFF_FFFF});
        check("hold_lo_in_run", {32'd0, lo}, {32'd0, 32'hFFFF_FFFA});
        wait_done();

        // DIV -7 / 2 = -3 rem -1, then the overflow corner
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_done();
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        wait_done();

        // DIVU by zero: flag held while idle
        issue(2'd3, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        wait_done();
        repeat (3) @(negedge clk);
        check("dbz_held", {63'd0, div_by_zero}, 64'd1);

        // DIVU 100 / 7 with a start and a lo write arriving while busy
        issue(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        check("dbz_cleared", {63'd0, div_by_zero}, 64'd0);
        repeat (5) @(negedge clk);
        start = 1'b1;
        op    = 2'd1;
        x     = 32'd3;
        y     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        lo_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        lo_we = 1'b0;
        check("lo_we_busy_ignored", {32'd0, lo}, {32'd0, 32'hFFFF_FFFF});
        check("hi_held_busy", {32'd0, hi}, {32'd0, 32'h0000_1234});
        wait_done();

        // Direct write of lo in IDLE
        lo_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        lo_we = 1'b0;
        check("lo_we_idle", {32'd0, lo}, {32'd0, 32'hDEAD_BEEF});
        check("hi_untouched", {32'd0, hi}, {32'd0, 32'd2});

        // Both registers written together
        @(negedge clk);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("hi_we_both", {32'd0, hi}, {32'd0, 32'h5555_AAAA});
        check("lo_we_both", {32'd0, lo}, {32'd0, 32'h5555_AAAA});

        // Start together with direct writes: the writes are dropped
        @(negedge clk);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h0000_0000;
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("start_wins_hi", {32'd0, hi}, {32'd0, 32'h5555_AAAA});
        check("start_wins_lo", {32'd0, lo}, {32'd0, 32'h5555_AAAA});
        wait_done();

        // Abort a MULTU with an asynchronous reset at edge 10
        @(negedge clk);
        issue(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        check("async_rst_hi", {32'd0, hi}, 64'd0);
        check("async_rst_lo", {32'd0, lo}, 64'd0);
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        check("async_rst_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // First edge after release accepts the restart
        issue(2'd1, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);
        wait_done();

        // Quiet period: any stray done is reported by the monitor
        repeat (40) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 start  input  1  operation request, sampled on the rising edge of clk.
REQ-004 op  input  2  operation: 0 MULT (signed), 1 MULTU, 2 DIV (signed), 3 DIVU.
REQ-005 x  input  32  multiplicand or dividend, captured on the accepting edge.
REQ-006 y  input  32  multiplier or divisor, captured on the accepting edge.
REQ-007 hi_we  input  1  direct write of hi (MTHI).
REQ-008 lo_we  input  1  direct write of lo (MTLO).
REQ-009 wdata  input  32  data for hi_we and lo_we.
REQ-010 busy  output  1  operation in progress; the pipeline stalls HI/LO consumers while this is high.
REQ-011 done  output  1  one-cycle pulse; hi and lo are valid when it is high.
REQ-012 hi  output  32  product[63:32] for multiply; remainder for divide.
REQ-013 lo  output  32  product[31:0] for multiply; quotient for divide.
REQ-014 div_by_zero  output  1  last completed divide had y == 0; held until the next accepted start.

Function
REQ-015 States: IDLE, RUN, FIX. No other state is reachable.
REQ-016 IDLE: start=1 at edge E0 -> capture op, x and y; clear div_by_zero; enter RUN; busy=1 from E0 onward.
REQ-017 RUN: exactly 32 iterations on edges E1..E32, one operand bit per edge.
- Multiply: shift-add on operand magnitudes.
- Divide: restoring shift-subtract on operand magnitudes.
REQ-018 FIX: at edge E33, apply signs, write hi and lo, set done=1, set busy=0, return to IDLE.
REQ-019 Fixed latency: done is high during the cycle after E33 (34 edges after acceptance), independent of operand values.
REQ-020 done SHALL be high for exactly one cycle per accepted operation.
REQ-021 start while busy=1 SHALL be ignored and not queued.
REQ-022 A new start is accepted at the same edge on which done is high (back-to-back operation).
REQ-023 MULT: {hi,lo} = signed 64-bit product of x and y.
REQ-024 MULTU: {hi,lo} = unsigned 64-bit product of x and y.
REQ-025 DIV: quotient truncates toward zero; remainder takes the sign of the dividend; x = lo*y + hi holds.
REQ-026 DIVU: lo = x / y; hi = x % y; both unsigned.
REQ-027 Divide with y == 0 (DIV or DIVU): lo=32'hFFFF_FFFF, hi=x, div_by_zero=1; latency is unchanged.
REQ-028 DIV with x=32'h8000_0000 and y=32'hFFFF_FFFF: lo=32'h8000_0000, hi=0; no trap and no flag.
REQ-029 hi_we or lo_we in IDLE: write wdata to the selected register at that edge. hi_we and lo_we together write both registers.
REQ-030 hi_we or lo_we while busy=1 SHALL be ignored.
REQ-031 hi_we or lo_we with start=1 in IDLE: start wins, and the direct write is dropped.
REQ-032 hi and lo SHALL hold their previous values throughout RUN; they change only at FIX, on a direct write, or on reset.

Reset
REQ-033 rst_n=0 SHALL immediately, without a clock edge, force: state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, and clear all internal iteration registers.
REQ-034 Reset asserted mid-operation SHALL abort the operation without a done pulse. The first edge after rst_n deasserts may accept a new start.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- MULT x=32'hFFFF_FFFE, y=3 -> done 34 edges after start; hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA.
- MULTU x=32'hFFFF_FFFE, y=3 -> hi=32'h0000_0002, lo=32'hFFFF_FFFA.
- DIV x=32'hFFFF_FFF9 (-7), y=2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF; then DIV x=32'h8000_0000, y=32'hFFFF_FFFF -> lo=32'h8000_0000, hi=0.
- DIVU x=32'h0000_1234, y=0 -> lo=32'hFFFF_FFFF, hi=32'h0000_1234, div_by_zero=1; the next accepted start clears the flag.
- DIVU 100/7 accepted, second start at edge 5 ignored, lo_we=1 with wdata=32'hDEAD_BEEF at edge 6 ignored -> single done, lo=14, hi=2; then lo_we in IDLE writes lo=32'hDEAD_BEEF.
- MULTU started, rst_n pulsed low at edge 10 -> outputs zero asynchronously and no done pulse; MULTU 5*6 restarted -> lo=30, hi=0 after 34 edges.
